mem_write_data_encoder: RTL and testbench

// Store-side counterpart of the load data path: takes CPU store requests (sw/sh/sb), places data on the

---
 rtl/mem_write_data_encoder.sv | 157 +++++++++++++++
 tb/tb_mem_write_data_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_write_data_encoder.sv
// Store-side data encoder: places sw/sh/sb data on big-endian byte lanes and queues it toward data memory.
// Optional MISALIGN_TRAP_EN: reject misaligned/illegal stores and report them on misalignErr/errAddr.
module mem_write_data_encoder #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stReq,
    output logic                  stReady,
    input  logic [ADDR_WIDTH-1:0] stAddr,
    input  logic [31:0]           stData,
    input  logic [1:0]            dataSize,
    output logic                  memWrEn,
    input  logic                  memReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWrData,
    output logic [3:0]            memByteEn,
    output logic                  bufEmpty,
    output logic                  misalignErr,
    output logic [ADDR_WIDTH-1:0] errAddr
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] addrQ [DEPTH];
    logic [31:0]           dataQ [DEPTH];
    logic [3:0]            enQ   [DEPTH];
    logic [PW-1:0]         wrPtr, rdPtr, rdNext;
    logic [CW-1:0]         count, countNext;

    logic [1:0]            off, lane;
    logic [ADDR_WIDTH-1:0] encAddr;
    logic [31:0]           encData;
    logic [3:0]            encEn;
    logic                  bad, accept, push, pop, headFromPush;
    logic [ADDR_WIDTH-1:0] headAddr;
    logic [31:0]           headData;
    logic [3:0]            headEn;

    assign off     = stAddr[1:0];
    assign lane    = 2'd3 - off;
    assign encAddr = {stAddr[ADDR_WIDTH-1:2], 2'b00};

    // Lane placement: lane 0 is [31:24] (offset 0), lane 3 is [7:0] (offset 3)
    always_comb begin
        encData = '0;
        encEn   = '0;
        case (dataSize)
            2'd0: begin
                encData = stData;
                encEn   = 4'b1111;
            end
            2'd1: begin
                if (off[1]) begin
                    encData = {16'h0, stData[15:0]};
                    encEn   = 4'b0011;
                end else begin
                    encData = {stData[15:0], 16'h0};
                    encEn   = 4'b1100;
                end
            end
            2'd2: begin
                encData = {24'h0, stData[7:0]} << {lane, 3'b000};
                encEn   = 4'b1000 >> off;
            end
            default: begin
                encData = '0;
                encEn   = '0;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign bad = ((dataSize == 2'd1) && off[0]) || ((dataSize == 2'd0) && (off != 2'd0)) ||
                 (dataSize == 2'd3);
`else
    assign bad = 1'b0;
`endif

    assign stReady = (count < CW'(DEPTH)) || (memWrEn && memReady);
    assign accept  = stReq && stReady;
    assign push    = accept && !bad;
    assign pop     = memWrEn && memReady;

    // Next head: freshly pushed entry when the buffer is (or becomes) empty, else the stored one
    always_comb begin
        countNext    = count + CW'(push) - CW'(pop);
        rdNext       = pop ? rdPtr + PW'(1) : rdPtr;
        headFromPush = push && (count == CW'(pop));
        headAddr     = addrQ[rdNext];
        headData     = dataQ[rdNext];
        headEn       = enQ[rdNext];
        if (headFromPush) begin
            headAddr = encAddr;
            headData = encData;
            headEn   = encEn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addrQ[i] <= '0;
                dataQ[i] <= '0;
                enQ[i]   <= '0;
            end
        end else begin
            if (push) begin
                addrQ[wrPtr] <= encAddr;
                dataQ[wrPtr] <= encData;
                enQ[wrPtr]   <= encEn;
                wrPtr        <= wrPtr + PW'(1);
            end
            rdPtr <= rdNext;
            count <= countNext;
        end
    end

    // Registered head presentation toward memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memWrEn   <= 1'b0;
            memAddr   <= '0;
            memWrData <= '0;
            memByteEn <= '0;
            bufEmpty  <= 1'b1;
        end else begin
            memWrEn  <= (countNext != '0);
            bufEmpty <= (countNext == '0);
            if (countNext != '0) begin
                memAddr   <= headAddr;
                memWrData <= headData;
                memByteEn <= headEn;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalignErr <= 1'b0;
            errAddr     <= '0;
        end else begin
            misalignErr <= accept && bad;
            if (accept && bad) errAddr <= stAddr;
        end
    end
`else
    assign misalignErr = 1'b0;
    assign errAddr     = '0;
`endif

endmodule

// File: tb/tb_mem_write_data_encoder.sv
// Scoreboard bench for mem_write_data_encoder: directed stores, monitor compares each memory write.
module tb_mem_write_data_encoder;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stReq;
    logic          stReady;
    logic [AW-1:0] stAddr;
    logic [31:0]   stData;
    logic [1:0]    dataSize;
    logic          memWrEn;
    logic          memReady;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWrData;
    logic [3:0]    memByteEn;
    logic          bufEmpty;
    logic          misalignErr;
    logic [AW-1:0] errAddr;

    int tests = 0;
    int fails = 0;
    logic [67:0] sbq [$];
    logic        holdValid = 1'b0;
    logic [67:0] held;

    mem_write_data_encoder #(.DEPTH(2), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stReq(stReq), .stReady(stReady), .stAddr(stAddr),
        .stData(stData), .dataSize(dataSize), .memWrEn(memWrEn), .memReady(memReady),
        .memAddr(memAddr), .memWrData(memWrData), .memByteEn(memByteEn), .bufEmpty(bufEmpty),
        .misalignErr(misalignErr), .errAddr(errAddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed memory write, and hold stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid && memWrEn)
                chk("hold_stable", {memAddr, memWrData, memByteEn}, held);
            if (memWrEn && memReady) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %h expected none", {memAddr, memWrData, memByteEn});
                end else begin
                    chk("mem_write", {memAddr, memWrData, memByteEn}, sbq.pop_front());
                end
            end
            holdValid = memWrEn && !memReady;
            held      = {memAddr, memWrData, memByteEn};
        end
    end

    // Issue one store from post-edge time; returns at post-edge time after the transfer
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input bit enq, input logic [31:0] expD, input logic [3:0] expEn);
        bit ok = 0;
        stReq = 1'b1; stAddr = a; stData = d; dataSize = sz;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = stReady;
            @(posedge clk);
        end
        if (ok && enq) sbq.push_back({a & 32'hFFFF_FFFC, expD, expEn});
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL store_timeout: got stReady=0 expected transfer for addr %h", a);
        end
        #1 stReq = 1'b0;
    endtask

    task automatic drain();
        memReady = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drained", 68'(sbq.size()), 68'd0);
    endtask

    initial begin
        rst_n = 1'b0; stReq = 1'b0; stAddr = '0; stData = '0; dataSize = '0; memReady = 1'b1;
        #12;
        chk("reset_out", {memWrEn, memAddr, memWrData, memByteEn}, '0);
        chk("reset_flags", {bufEmpty, misalignErr, errAddr}, {1'b1, 1'b0, 32'h0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: byte at offset 3, visible the cycle after acceptance
        store(32'h103, 32'hAB, 2'd2, 1, 32'h0000_00AB, 4'b0001);
        chk("sb_latency", {memWrEn, memAddr, memWrData, memByteEn}, {1'b1, 32'h100, 32'hAB, 4'b0001});
        chk("sb_notempty", 68'(bufEmpty), 68'd0);
        // 2: halves kept in order; other byte lanes and a word
        store(32'h200, 32'h1234, 2'd1, 1, 32'h1234_0000, 4'b1100);
        store(32'h202, 32'h5678, 2'd1, 1, 32'h0000_5678, 4'b0011);
        store(32'h500, 32'hCD, 2'd2, 1, 32'hCD00_0000, 4'b1000);
        store(32'h501, 32'hEF, 2'd2, 1, 32'h00EF_0000, 4'b0100);
        store(32'h502, 32'h11, 2'd2, 1, 32'h0000_1100, 4'b0010);
        store(32'h400, 32'hDEAD_BEEF, 2'd0, 1, 32'hDEAD_BEEF, 4'b1111);
        drain();

        // 3: fill with memory stalled, then push+pop on full
        memReady = 1'b0;
        store(32'h10, 32'h1111_1111, 2'd0, 1, 32'h1111_1111, 4'b1111);
        store(32'h14, 32'h2222_2222, 2'd0, 1, 32'h2222_2222, 4'b1111);
        fork
            store(32'h18, 32'h3333_3333, 2'd0, 1, 32'h3333_3333, 4'b1111);
            begin
                @(negedge clk);
                chk("full_notready", 68'(stReady), 68'd0);
                repeat (2) @(posedge clk);
                #1 memReady = 1'b1;
            end
        join
        memReady = 1'b0;
        @(negedge clk);
        chk("full_after_pushpop", {stReady, memWrEn, bufEmpty}, {1'b0, 1'b1, 1'b0});
        drain();

        // 4: memReady toggling during a burst of words
        memReady = 1'b0;
        fork
            begin
                store(32'h800, 32'hA0A0_A0A0, 2'd0, 1, 32'hA0A0_A0A0, 4'b1111);
                store(32'h804, 32'hB1B1_B1B1, 2'd0, 1, 32'hB1B1_B1B1, 4'b1111);
                store(32'h808, 32'hC2C2_C2C2, 2'd0, 1, 32'hC2C2_C2C2, 4'b1111);
                store(32'h80C, 32'hD3D3_D3D3, 2'd0, 1, 32'hD3D3_D3D3, 4'b1111);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk);
                    #1 memReady = ~memReady;
                end
            end
        join
        drain();

        // 5: reset mid-drain drops pending entries
        memReady = 1'b0;
        store(32'h900, 32'h1, 2'd0, 1, 32'h1, 4'b1111);
        store(32'h904, 32'h2, 2'd0, 1, 32'h2, 4'b1111);
        @(posedge clk); #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("rst_mid_out", {memWrEn, memAddr, memWrData, memByteEn}, '0);
        chk("rst_mid_empty", 68'(bufEmpty), 68'd1);
        @(negedge clk) rst_n = 1'b1;
        memReady = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rst_no_write", {memWrEn, bufEmpty}, {1'b0, 1'b1});

        // 6: misaligned word, odd half and illegal size
`ifdef MISALIGN_TRAP_EN
        store(32'h302, 32'hCAFE_F00D, 2'd0, 0, 32'h0, 4'b0000);
        chk("trap_pulse", {misalignErr, errAddr}, {1'b1, 32'h302});
        chk("trap_not_queued", {memWrEn, bufEmpty}, {1'b0, 1'b1});
        @(posedge clk); #1;
        chk("trap_one_cycle", {misalignErr, errAddr}, {1'b0, 32'h302});
        store(32'h701, 32'hBEEF, 2'd1, 0, 32'h0, 4'b0000);
        chk("trap_half", {misalignErr, errAddr}, {1'b1, 32'h701});
        store(32'h600, 32'h99, 2'd3, 0, 32'h0, 4'b0000);
        chk("trap_size3", {misalignErr, errAddr}, {1'b1, 32'h600});
`else
        store(32'h302, 32'hCAFE_F00D, 2'd0, 1, 32'hCAFE_F00D, 4'b1111);
        chk("notrap_err", {misalignErr, errAddr}, '0);
        store(32'h701, 32'hBEEF, 2'd1, 1, 32'hBEEF_0000, 4'b1100);
        store(32'h600, 32'h99, 2'd3, 1, 32'h0, 4'b0000);
        chk("notrap_err2", {misalignErr, errAddr}, '0);
`endif
        drain();
        chk("final_empty", 68'(bufEmpty), 68'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
